ttl_74298_capture_sched: RTL

// Capture scheduler for one SN74LS298-style quad 2-input mux latch (sync model: capture on Cen falling edge).

---
 rtl/ttl_74298_capture_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ttl_74298_capture_sched.sv
// rtl/ttl_74298_capture_sched.sv - capture scheduler for one SN74LS298-style mux latch (option macro: MUX298_SCHED_RR_EN)
module ttl_74298_capture_sched #(
  parameter int STROBE_W = 1,
  parameter int MIN_GAP  = 1
) (
  input  logic clk,
  input  logic VIDEO_RSTn,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic ack_a,
  output logic ack_b,
  output logic ws,
  output logic cen,
  output logic cap_valid,
  output logic cap_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_W - 1);
  localparam logic [3:0] GAP_LOAD    = 4'(MIN_GAP - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       grant_ok;
  logic       decide;
  logic       take;
  logic       win;

  assign grant_ok = en && (req_a || req_b);
  // Decision edges: any IDLE cycle, or the last cycle of the recovery gap.
  assign decide   = (state == IDLE) || ((state == GAP) && (cnt == 4'd0));
  assign take     = grant_ok && decide;

`ifdef MUX298_SCHED_RR_EN
  logic rr_ptr;

  // Winner: pointer breaks ties, a lone requester always wins.
  always_comb begin
    win = req_b;
    if (req_a && req_b) win = rr_ptr;
  end

  // Pointer flips to the other source after every grant.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) rr_ptr <= 1'b0;
    else if (take)   rr_ptr <= ~win;
  end
`else
  // Winner: A takes every tie, B only when A is not requesting.
  always_comb begin
    win = !req_a;
  end
`endif

  // Strobe sequencer; every output is a register so req never reaches an output combinationally.
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cen       <= 1'b1;
      ws        <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      cap_valid <= 1'b0;
      cap_owner <= 1'b0;
    end else begin
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      // The latch captures at the edge ending the ack cycle, so Q is new from the next cycle.
      cap_valid <= ack_a | ack_b;
      if (ack_a || ack_b) cap_owner <= ws;

      case (state)
        IDLE: begin
          cen <= 1'b1;
          if (take) begin
            state <= STROBE;
            ws    <= win;
            cen   <= 1'b0;
            ack_a <= !win;
            ack_b <= win;
            cnt   <= STROBE_LOAD;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state <= GAP;
            cen   <= 1'b1;
            cnt   <= GAP_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (take) begin
            // Gap already gave cen at least one high cycle, so this is a clean falling edge.
            state <= STROBE;
            ws    <= win;
            cen   <= 1'b0;
            ack_a <= !win;
            ack_b <= win;
            cnt   <= STROBE_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cen   <= 1'b1;
        end
      endcase
    end
  end

endmodule
